// File: rtl/uart_param.sv
// rtl/uart_param.sv - Parametrised full-duplex UART with per-frame parity/framing status.
// Optional macro UART_LOOPBACK_EN adds a loopback input routing the internal TX line into RX.
module uart_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] inputData,
    input  logic                 txStart,
    output logic                 txBusy,
    output logic                 serialOutput,
    input  logic                 serialInput,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic [DATA_BITS-1:0] outputData,
    output logic                 rxValid,
    output logic                 rxParityError,
    output logic                 rxFrameError
);
    localparam int            TW     = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    tx_state_t            r_tx_state;
    logic [TW-1:0]        r_tx_timer;
    logic [3:0]           r_tx_bit;
    logic                 r_tx_stop;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_busy;
    logic                 r_tx_line;

    rx_state_t            r_rx_state;
    logic                 r_rx_s1;
    logic                 r_rx_s2;
    logic                 r_rx_prev;
    logic [TW-1:0]        r_rx_timer;
    logic [3:0]           r_rx_bit;
    logic                 r_rx_stop;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_bad;
    logic                 r_rx_frame_bad;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_perr;
    logic                 r_rx_ferr;

    logic                 w_rx_pin;
    logic                 w_rx_sample;

`ifdef UART_LOOPBACK_EN
    assign w_rx_pin     = loopback ? r_tx_line : serialInput;
    assign serialOutput = loopback | r_tx_line;
`else
    assign w_rx_pin     = serialInput;
    assign serialOutput = r_tx_line;
`endif

    assign txBusy        = r_tx_busy;
    assign outputData    = r_rx_data;
    assign rxValid       = r_rx_valid;
    assign rxParityError = r_rx_perr;
    assign rxFrameError  = r_rx_ferr;
    assign w_rx_sample   = (r_rx_timer == T_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_timer <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_busy  <= 1'b0;
            r_tx_line  <= 1'b1;
        end else if (r_tx_state == TX_IDLE) begin
            if (enable && txStart && !r_tx_busy) begin
                r_tx_shift <= inputData;
                r_tx_par   <= (PARITY == 1) ? ~(^inputData) : (^inputData);
                r_tx_busy  <= 1'b1;
                r_tx_line  <= 1'b0;
                r_tx_timer <= '0;
                r_tx_state <= TX_START;
            end
        end else if (r_tx_timer != T_LAST) begin
            r_tx_timer <= r_tx_timer + 1'b1;
        end else begin
            r_tx_timer <= '0;
            case (r_tx_state)
                TX_START: begin
                    r_tx_line  <= r_tx_shift[0];
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= '0;
                    r_tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    if (r_tx_bit == D_LAST) begin
                        r_tx_stop <= 1'b0;
                        if (PARITY != 0) begin
                            r_tx_line  <= r_tx_par;
                            r_tx_state <= TX_PARITY;
                        end else begin
                            r_tx_line  <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end
                    end else begin
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= r_tx_bit + 1'b1;
                    end
                end
                TX_PARITY: begin
                    r_tx_line  <= 1'b1;
                    r_tx_state <= TX_STOP;
                end
                TX_STOP: begin
                    if (r_tx_stop == S_LAST) begin
                        r_tx_busy  <= 1'b0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_stop <= 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX timer restarts at 1 on the detected edge so START samples T_HALF cycles into the bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state     <= RX_IDLE;
            r_rx_s1        <= 1'b1;
            r_rx_s2        <= 1'b1;
            r_rx_prev      <= 1'b1;
            r_rx_timer     <= '0;
            r_rx_bit       <= '0;
            r_rx_stop      <= 1'b0;
            r_rx_shift     <= '0;
            r_rx_par_bad   <= 1'b0;
            r_rx_frame_bad <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_perr      <= 1'b0;
            r_rx_ferr      <= 1'b0;
        end else begin
            r_rx_s1    <= w_rx_pin;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_valid <= 1'b0;
            if (r_rx_state != RX_IDLE && r_rx_state != RX_BREAK) begin
                r_rx_timer <= w_rx_sample ? '0 : r_rx_timer + 1'b1;
            end
            case (r_rx_state)
                RX_IDLE: begin
                    if (enable && r_rx_prev && !r_rx_s2) begin
                        r_rx_timer     <= TW'(1);
                        r_rx_par_bad   <= 1'b0;
                        r_rx_frame_bad <= 1'b0;
                        r_rx_state     <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_timer == T_HALF) begin
                        r_rx_timer <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_rx_sample) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_stop  <= 1'b0;
                        if (r_rx_bit == D_LAST) begin
                            r_rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (w_rx_sample) begin
                        r_rx_par_bad <= (PARITY == 1) ? ~(^{r_rx_shift, r_rx_s2})
                                                      : (^{r_rx_shift, r_rx_s2});
                        r_rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (w_rx_sample) begin
                        if (r_rx_stop == S_LAST) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= r_rx_shift;
                            r_rx_perr  <= (PARITY != 0) && r_rx_par_bad;
                            r_rx_ferr  <= r_rx_frame_bad | ~r_rx_s2;
                            r_rx_state <= (r_rx_frame_bad | ~r_rx_s2) ? RX_BREAK : RX_IDLE;
                        end else begin
                            r_rx_stop      <= 1'b1;
                            r_rx_frame_bad <= r_rx_frame_bad | ~r_rx_s2;
                        end
                    end
                end
                RX_BREAK: begin
                    if (r_rx_s2) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_param.sv
// tb/tb_uart_param.sv - Self-checking bench for uart_param (8 data, 4 clk/bit, even parity, 1 stop).
module tb_uart_param;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] inputData;
    logic       txStart;
    logic       txBusy;
    logic       serialOutput;
    logic       serialInput;
    logic [7:0] outputData;
    logic       rxValid;
    logic       rxParityError;
    logic       rxFrameError;
`ifdef UART_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [9:0] rx_q[$];

    uart_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .inputData(inputData),
        .txStart(txStart), .txBusy(txBusy), .serialOutput(serialOutput),
        .serialInput(serialInput),
`ifdef UART_LOOPBACK_EN
        .loopback(loopback),
`endif
        .outputData(outputData), .rxValid(rxValid),
        .rxParityError(rxParityError), .rxFrameError(rxFrameError)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxValid === 1'b1) rx_q.push_back({rxParityError, rxFrameError, outputData});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bit k sits at index k: start, data LSB first, even parity, stop
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit bad_par, input bit stop);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = d;
        f[9]   = (($countones(d) % 2) == 1) ^ bad_par;
        f[10]  = stop;
        return f;
    endfunction

    task automatic drive_level(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            serialInput = v;
        end
    endtask

    task automatic rx_frame(input logic [10:0] f, input int nbits);
        for (int b = 0; b < nbits; b++) drive_level(f[b], 4);
    endtask

    task automatic expect_rx(input logic [7:0] d, input logic pe, input logic fe);
        logic [9:0] e;
        int n = 0;
        while (rx_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rx_pulses", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            e = rx_q.pop_front();
            check("rx_data", e[7:0], d);
            check("rx_perr", e[9], pe);
            check("rx_ferr", e[8], fe);
        end
        rx_q.delete();
    endtask

    task automatic tx_frame(input logic [7:0] d, input bit mid_pulse, input bit lb);
        logic [10:0] f;
        int n = 0;
        f = frame_bits(d, 1'b0, 1'b1);
        while (txBusy && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        inputData = d;
        txStart   = 1'b1;
        @(negedge clk);
        txStart   = 1'b0;
        inputData = 8'($urandom);
        for (int k = 0; k < 44; k++) begin
            if (k > 0) @(negedge clk);
            txStart = (mid_pulse && k == 10);
            check("tx_busy", txBusy, 1);
            check("tx_line", serialOutput, lb ? 1'b1 : f[k / 4]);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            txStart = 1'b0;
            check("tx_busy_after", txBusy, 0);
            check("tx_line_after", serialOutput, 1);
        end
    endtask

    initial begin
        logic [7:0] d_tx;
        logic [7:0] d_rx;
        bit         bad;
        reset = 1'b1; enable = 1'b1; txStart = 1'b0; inputData = '0; serialInput = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_line", serialOutput, 1);
        check("rst_busy", txBusy, 0);
        check("rst_valid", rxValid, 0);
        check("rst_data", outputData, 0);
        check("rst_flags", {rxParityError, rxFrameError}, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        tx_frame(8'hAA, 1'b1, 1'b0);

        rx_frame(frame_bits(8'h3C, 1'b0, 1'b1), 11);
        drive_level(1'b1, 8);
        expect_rx(8'h3C, 1'b0, 1'b0);

        rx_frame(frame_bits(8'h3C, 1'b1, 1'b1), 11);
        drive_level(1'b1, 8);
        expect_rx(8'h3C, 1'b1, 1'b0);

        rx_frame(frame_bits(8'h55, 1'b0, 1'b0), 10);
        drive_level(1'b0, 20);
        drive_level(1'b1, 8);
        expect_rx(8'h55, 1'b0, 1'b1);

        rx_frame(frame_bits(8'hA5, 1'b0, 1'b1), 11);
        drive_level(1'b1, 8);
        expect_rx(8'hA5, 1'b0, 1'b0);

        drive_level(1'b0, 1);
        drive_level(1'b1, 12);
        check("glitch_no_rx", rx_q.size(), 0);

        enable = 1'b0;
        @(negedge clk); txStart = 1'b1;
        @(negedge clk); txStart = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("disabled_tx_busy", txBusy, 0);
        end
        rx_frame(frame_bits(8'h0F, 1'b0, 1'b1), 11);
        drive_level(1'b1, 8);
        check("disabled_no_rx", rx_q.size(), 0);
        enable = 1'b1;
        drive_level(1'b1, 4);

        for (int i = 0; i < 6; i++) begin
            d_tx = 8'($urandom);
            d_rx = 8'($urandom);
            bad  = 1'($urandom_range(0, 1));
            fork
                tx_frame(d_tx, 1'b0, 1'b0);
                begin
                    rx_frame(frame_bits(d_rx, bad, 1'b1), 11);
                    drive_level(1'b1, 8);
                end
            join
            expect_rx(d_rx, bad, 1'b0);
        end

        rx_frame(frame_bits(8'hA5, 1'b0, 1'b1), 11);
        drive_level(1'b1, 8);
        expect_rx(8'hA5, 1'b0, 1'b0);
        fork
            begin
                @(negedge clk); inputData = 8'h99; txStart = 1'b1;
                @(negedge clk); txStart = 1'b0;
            end
            rx_frame(frame_bits(8'h66, 1'b0, 1'b1), 5);
        join
        #1 reset = 1'b1; serialInput = 1'b1;
        #1;
        check("midrst_line", serialOutput, 1);
        check("midrst_busy", txBusy, 0);
        check("midrst_valid", rxValid, 0);
        check("midrst_data", outputData, 0);
        check("midrst_flags", {rxParityError, rxFrameError}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_rx", rx_q.size(), 0);
        fork
            tx_frame(8'hF0, 1'b0, 1'b0);
            begin
                rx_frame(frame_bits(8'hF0, 1'b0, 1'b1), 11);
                drive_level(1'b1, 8);
            end
        join
        expect_rx(8'hF0, 1'b0, 1'b0);

`ifdef UART_LOOPBACK_EN
        loopback = 1'b1;
        repeat (3) @(negedge clk);
        tx_frame(8'h81, 1'b0, 1'b1);
        expect_rx(8'h81, 1'b0, 1'b0);
        loopback = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
